// File: rtl/isram_arb.sv
// ---------------------------------------------------------------------------
// isram_arb -- two-port arbiter in front of a single-ported instruction SRAM.
//
// The fetch port (read-only) and the system/loader port (read/write) share a
// single SRAM.
//   * Normally fetch has priority, so the system port only gets the SRAM when
//     fetch is idle.
//   * A starvation counter forces one system grant after STARVE_LIM
//     consecutive denied cycles.
//   * Read data returns one cycle after the select.
//   * A registered response owner steers that data to the fetch stage or to
//     the system port.
//   * The last fetch word is held so the fetch stage sees a stable
//     instruction while it is stalled.
//
// Ports
//   clk, cpurst             clock, async active-high reset
//   isram_cs, isram_adr     fetch read request / doubleword address
//   sys_req/we/adr/wdata/wmask
//                           system port request, held until sys_gnt
//   sram_rdata              SRAM read data (one cycle after a read select)
//   sram_cs/we/adr/wdata/wmask
//                           SRAM command for the winning port
//   sys_gnt                 system request accepted this cycle
//   sys_rvalid, sys_rdata   system read response
//   fet_arb_stall           fetch denied this cycle, must re-present
//   instr_fromsram          fetch data (live SRAM data or held word)
// ---------------------------------------------------------------------------
module isram_arb #(
  parameter int unsigned STARVE_LIM = 7
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        isram_cs,
  input  logic [31:3] isram_adr,
  input  logic        sys_req,
  input  logic        sys_we,
  input  logic [31:3] sys_adr,
  input  logic [63:0] sys_wdata,
  input  logic [7:0]  sys_wmask,
  input  logic [63:0] sram_rdata,
  output logic        sram_cs,
  output logic        sram_we,
  output logic [31:3] sram_adr,
  output logic [63:0] sram_wdata,
  output logic [7:0]  sram_wmask,
  output logic        sys_gnt,
  output logic        sys_rvalid,
  output logic [63:0] sys_rdata,
  output logic        fet_arb_stall,
  output logic [63:0] instr_fromsram
);

  localparam logic [1:0]  OWN_NONE = 2'd0;
  localparam logic [1:0]  OWN_FET  = 2'd1;
  localparam logic [1:0]  OWN_SYS  = 2'd2;
  localparam logic [3:0]  LIM      = 4'(STARVE_LIM);
  localparam logic [63:0] NOP_PAIR = 64'h00000013_00000013;

  logic [3:0]  starve_q, starve_d;
  logic [1:0]  owner_q,  owner_d;
  logic [63:0] hold_q,   hold_d;

  logic sys_win, fet_win;

  // Grant decision.
  //   * Fetch wins every contended cycle unless the system port has been
  //     starved for STARVE_LIM cycles.
  //   * Reset masks both grants, so nothing reaches the SRAM while cpurst
  //     is high.
  always_comb begin
    sys_win = 1'b0;
    fet_win = 1'b0;
    if (!cpurst) begin
      sys_win = sys_req && (!isram_cs || (starve_q == LIM));
      fet_win = isram_cs && !sys_win;
    end
  end

  // SRAM command from the winner; all-zero when idle.
  always_comb begin
    sram_cs    = sys_win | fet_win;
    sram_we    = 1'b0;
    sram_adr   = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (sys_win) begin
      sram_we    = sys_we;
      sram_adr   = sys_adr;
      sram_wdata = sys_wdata;
      sram_wmask = sys_wmask;
    end else if (fet_win) begin
      sram_adr   = isram_adr;
    end
  end

  assign sys_gnt       = sys_win;
  assign fet_arb_stall = isram_cs && !fet_win && !cpurst;

  // Starvation counter, which counts consecutive denied system cycles.
  //   * It saturates at the limit, so the forced grant sees exactly LIM.
  //   * A grant clears it, so two forced grants can never occur back to back.
  always_comb begin
    starve_d = 4'd0;
    if (sys_req && !sys_win)
      starve_d = (starve_q == LIM) ? LIM : starve_q + 4'd1;
  end

  // Response owner for the data returning next cycle. System writes
  // complete in their grant cycle and produce no response.
  always_comb begin
    owner_d = OWN_NONE;
    if (fet_win)
      owner_d = OWN_FET;
    else if (sys_win && !sys_we)
      owner_d = OWN_SYS;
  end

  // Capture every fetch word so a stalled fetch stage keeps seeing it.
  always_comb begin
    hold_d = hold_q;
    if (owner_q == OWN_FET)
      hold_d = sram_rdata;
  end

  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
      hold_q   <= NOP_PAIR;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
    end
  end

  assign sys_rvalid     = (owner_q == OWN_SYS);
  assign sys_rdata      = sys_rvalid ? sram_rdata : 64'd0;
  assign instr_fromsram = (owner_q == OWN_FET) ? sram_rdata : hold_q;

endmodule

// File: doc/isram_arb.md
ISRAM_ARB -- requirements
Module: isram_arb

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 7, giving the number of consecutive cycles the system port may be denied before it is forced a grant (legal range 1..15).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port cpurst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port isram_cs  in  1  fetch read request.
REQ-005 SHALL have port isram_adr  in  [31:3]  fetch doubleword address.
REQ-006 SHALL have port sys_req  in  1  system/loader port request.
REQ-007 SHALL have port sys_we  in  1  system port write (1) or read (0).
REQ-008 SHALL have port sys_adr  in  [31:3]  system port doubleword address.
REQ-009 SHALL have port sys_wdata  in  [63:0]  system port write data.
REQ-010 SHALL have port sys_wmask  in  [7:0]  system port byte enables.
REQ-011 SHALL have port sram_rdata  in  [63:0]  SRAM read data, valid the cycle after a read select.
REQ-012 SHALL have port sram_cs  out  1  SRAM select.
REQ-013 SHALL have port sram_we  out  1  SRAM write enable.
REQ-014 SHALL have port sram_adr  out  [31:3]  SRAM address.
REQ-015 SHALL have port sram_wdata  out  [63:0]  SRAM write data.
REQ-016 SHALL have port sram_wmask  out  [7:0]  SRAM byte enables.
REQ-017 SHALL have port sys_gnt  out  1  system request accepted this cycle.
REQ-018 SHALL have port sys_rvalid  out  1  sys_rdata valid.
REQ-019 SHALL have port sys_rdata  out  [63:0]  system read data.
REQ-020 SHALL have port fet_arb_stall  out  1  fetch request denied this cycle; fetch must re-present it.
REQ-021 SHALL have port instr_fromsram  out  [63:0]  fetch data to the fetch stage.

Function
REQ-022 SHALL compute the grant combinationally each cycle: the system port wins if sys_req and (not isram_cs, or starve_cnt equals STARVE_LIM); otherwise fetch wins if isram_cs; otherwise there is no grant.
REQ-023 SHALL drive sram_cs equal to (any grant); sram_adr, sram_we, sram_wdata and sram_wmask from the winner; when fetch wins, sram_we=0 and sram_wmask=0; with no grant, all SRAM outputs are 0.
REQ-024 SHALL assert sys_gnt in the cycle the system port wins, and fet_arb_stall in the cycle isram_cs is high but fetch loses.
REQ-025 SHALL keep a 4-bit starve_cnt: it increments when sys_req and not sys_gnt, saturates at STARVE_LIM, and clears when sys_gnt is high or sys_req is low.
REQ-026 SHALL register resp_owner (NONE/FET/SYS) each cycle: FET after a fetch grant, SYS after a system read grant, NONE otherwise (including system writes).
REQ-027 SHALL drive instr_fromsram equal to sram_rdata when resp_owner=FET; otherwise it equals hold_instr.
REQ-028 SHALL load hold_instr with sram_rdata on every cycle where resp_owner=FET.
REQ-029 SHALL assert sys_rvalid for exactly one cycle, the cycle after a system read grant, with sys_rdata=sram_rdata; sys_rdata SHALL be 0 otherwise.
REQ-030 SHALL give a system write 0 cycles of response latency: it completes in its grant cycle, and no sys_rvalid is produced for it.
REQ-031 SHALL require sys_req, sys_we, sys_adr, sys_wdata and sys_wmask to be held stable by the requester until sys_gnt; the block SHALL NOT latch unaccepted requests.
REQ-032 SHALL NOT let a forced system grant (starvation) occur on two consecutive cycles, because starve_cnt clears on grant; fetch then wins the next contended cycle.

Reset
REQ-033 SHALL, while cpurst is high, asynchronously set starve_cnt=0, resp_owner=NONE and hold_instr=64'h00000013_00000013 (two NOPs).
REQ-034 SHALL, while cpurst is high, hold sram_cs, sys_gnt, sys_rvalid and fet_arb_stall at 0 regardless of inputs.
REQ-035 SHALL drop an in-flight response if reset asserts mid-operation: no sys_rvalid after reset release, and instr_fromsram equals the NOP pair.

Verification
REQ-036 SHALL be covered by this scenario: fetch-only, isram_adr=0x10>>3 -> next cycle instr_fromsram=sram_rdata, fet_arb_stall=0.
REQ-037 SHALL be covered by this scenario: sys read only, sys_adr=0x40>>3 -> sys_gnt=1 that cycle, sys_rvalid=1 next cycle with the SRAM data, then 0.
REQ-038 SHALL be covered by this scenario: isram_cs and sys_req held high continuously, STARVE_LIM=7 -> sys_gnt on the 8th cycle only, fet_arb_stall=1 in that cycle, and instr_fromsram holds the previous fetch word the following cycle.
REQ-039 SHALL be covered by this scenario: sys write, wmask=8'h0F, with isram_cs low -> sram_we=1, sram_wmask=8'h0F same cycle, and no sys_rvalid.
REQ-040 SHALL be covered by this scenario: cpurst asserted the cycle after a sys read grant -> sys_rvalid stays 0, and instr_fromsram=64'h00000013_00000013.
